// File: rtl/de_ustb_pkg.sv
// Shared constants and helpers for the de_ustb input conditioner and its siblings.
package de_ustb_pkg;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/de_ustb_sync.sv
// N-stage flip-flop synchroniser for a single asynchronous bit, async active-high reset.
module de_ustb_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/de_ustb.sv
// Synchronise, debounce and edge-detect a bouncy async level; emits a one-cycle strobe
// each time a debounced 0->1 transition is accepted.
module de_ustb
  import de_ustb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int unsigned      CNT_W  = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             synced;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  de_ustb_sync #(
    .Stages(SYNC_STAGES)
  ) u_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (in),
    .q_o  (synced)
  );

  // Any return to the stable level restarts the count, so short glitches are dropped.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    out_d    = 1'b0;
    if (synced != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = synced;
        out_d    = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      out_q    <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_de_ustb.sv
// Bench for de_ustb: default build and an S=3/D=1 build share stimulus; both are
// compared every cycle against a history-based reference model plus absolute latency checks.
module tb_de_ustb;

  localparam int unsigned SA = 2;
  localparam int unsigned DA = 16;
  localparam int unsigned SB = 3;
  localparam int unsigned DB = 1;

  logic clk;
  logic rst;
  logic in;
  logic out_a;
  logic out_b;

  int n_chk;
  int n_fail;

  de_ustb u_dut_a (
    .clk(clk),
    .rst(rst),
    .in (in),
    .out(out_a)
  );

  de_ustb #(
    .SYNC_STAGES    (SB),
    .DEBOUNCE_CYCLES(DB)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .in (in),
    .out(out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: level seen by debounce at edge n is the input sampled S edges earlier;
  // a new level is accepted after D consecutive edges of disagreement.
  bit hist_a[$];
  bit hist_b[$];
  bit stable_m[2];
  int run_m[2];
  bit exp_out[2];

  // Per-segment observation of DUT strobes.
  int pulses_a, pulses_b, first_a, first_b, edge_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist_a.delete();
    hist_b.delete();
    for (int i = 0; i < int'(SA); i++) hist_a.push_back(1'b0);
    for (int i = 0; i < int'(SB); i++) hist_b.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      stable_m[i] = 1'b0;
      run_m[i]    = 0;
      exp_out[i]  = 1'b0;
    end
  endtask

  task automatic model_debounce(input int idx, input bit seen, input int d);
    exp_out[idx] = 1'b0;
    if (seen == stable_m[idx]) begin
      run_m[idx] = 0;
    end else begin
      run_m[idx]++;
      if (run_m[idx] == d) begin
        stable_m[idx] = seen;
        run_m[idx]    = 0;
        exp_out[idx]  = seen;
      end
    end
  endtask

  task automatic model_step(input bit din);
    bit seen;
    seen = hist_a.pop_front();
    hist_a.push_back(din);
    model_debounce(0, seen, int'(DA));
    seen = hist_b.pop_front();
    hist_b.push_back(din);
    model_debounce(1, seen, int'(DB));
  endtask

  task automatic seg_start();
    pulses_a = 0;
    pulses_b = 0;
    first_a  = 0;
    first_b  = 0;
    edge_n   = 0;
  endtask

  // One clock edge; inputs change only at negedge, outputs checked at negedge.
  task automatic tick();
    @(posedge clk);
    model_step(in);
    @(negedge clk);
    edge_n++;
    check("out_a", 32'(out_a), 32'(exp_out[0]));
    check("out_b", 32'(out_b), 32'(exp_out[1]));
    if (out_a === 1'b1) begin
      pulses_a++;
      if (first_a == 0) first_a = edge_n;
    end
    if (out_b === 1'b1) begin
      pulses_b++;
      if (first_b == 0) first_b = edge_n;
    end
  endtask

  // Called just after a negedge; checks that out drops without a clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_a", 32'(out_a), 32'd0);
    check("rst_async_b", 32'(out_b), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold_a", 32'(out_a), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int run_len;
    bit lvl;
    n_chk  = 0;
    n_fail = 0;
    in     = 1'b0;
    rst    = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: clean rise, single strobe at edge S+D
    repeat (3) tick();
    in = 1'b1;
    seg_start();
    repeat (30) tick();
    check("t1_first_a", 32'(first_a), 32'(SA + DA));
    check("t1_count_a", 32'(pulses_a), 32'd1);
    check("t1_first_b", 32'(first_b), 32'(SB + DB));
    check("t1_count_b", 32'(pulses_b), 32'd1);

    // 2: pulse shorter than D never accepted
    do_reset();
    in = 1'b1;
    seg_start();
    repeat (10) tick();
    in = 1'b0;
    repeat (30) tick();
    check("t2_count_a", 32'(pulses_a), 32'd0);

    // 3: bounce then hold high
    do_reset();
    seg_start();
    for (int i = 0; i < 4; i++) begin
      in = (i % 2 == 0);
      repeat (3) tick();
    end
    check("t3_bounce_a", 32'(pulses_a), 32'd0);
    in = 1'b1;
    seg_start();
    repeat (25) tick();
    check("t3_first_a", 32'(first_a), 32'(SA + DA));
    check("t3_count_a", 32'(pulses_a), 32'd1);

    // 4: accepted fall is silent, re-rise strobes again
    in = 1'b0;
    seg_start();
    repeat (20) tick();
    check("t4_fall_a", 32'(pulses_a), 32'd0);
    in = 1'b1;
    seg_start();
    repeat (25) tick();
    check("t4_first_a", 32'(first_a), 32'(SA + DA));
    check("t4_count_a", 32'(pulses_a), 32'd1);

    // 5: reset mid-count, then reset while strobe is high
    do_reset();
    in = 1'b1;
    repeat (SA + 10) tick();
    do_reset();
    seg_start();
    repeat (SA + DA) tick();
    check("t5_pre_a", 32'(out_a), 32'd1);
    do_reset();
    seg_start();
    repeat (25) tick();
    check("t5_first_a", 32'(first_a), 32'(SA + DA));
    check("t5_count_a", 32'(pulses_a), 32'd1);

    // Random runs of random length, occasional reset
    for (int r = 0; r < 120; r++) begin
      lvl     = 1'($urandom_range(0, 1));
      run_len = int'($urandom_range(1, 24));
      in      = lvl;
      repeat (run_len) tick();
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/de_ustb.md
Name: de_ustb

Overview:
- Input conditioner for asynchronous, possibly bouncy single-bit control inputs, e.g. the xcorr-enable pad.
- Three stages: the input is synchronised into the `clk` domain, debounced by a stable-duration counter, and reduced to a one-cycle rising-edge strobe on `out`.
- Sits between a pad/bench-driven enable and logic that needs a clean single start pulse, such as the cross-correlator start.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the synchroniser chain; legal range ≥ 2.
- DEBOUNCE_CYCLES, 16, consecutive synchronised cycles the new level must hold before it is accepted; legal range ≥ 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in   input  1  raw asynchronous level input.
- out  input/output: output  1  registered one-cycle strobe, high when a debounced 0→1 transition is accepted.

Behaviour:
- Reset (async assert; synchronous-safe deassert is the integrator's job):
  - sync chain = 0, stable level = 0, counter = 0, out = 0.
  - out goes 0 immediately on assertion, without waiting for a clock edge.
- Synchroniser:
  - sync[0] <= in; sync[i] <= sync[i-1].
  - synced = sync[SYNC_STAGES-1].
  - No logic may read `in` except sync[0].
- Debounce, evaluated each edge:
  - synced == stable: counter <= 0.
  - synced != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - synced != stable and counter == DEBOUNCE_CYCLES-1: stable <= synced, counter <= 0.
- Strobe:
  - out <= 1 on the same edge where stable updates 0→1; otherwise out <= 0.
  - out is never high for two consecutive cycles.
  - A 1→0 acceptance updates stable and produces no strobe.
- Latency:
  - Take in held at 1 from sampling edge k onward.
  - out is high for exactly the one cycle following edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. the (S+D)th sampling edge.
  - Defaults: out rises after the 18th edge and falls after the 19th.
- Glitch rejection: any synced excursion shorter than DEBOUNCE_CYCLES cycles resets the counter on return and leaves stable and out unchanged.
- DEBOUNCE_CYCLES = 1: acceptance occurs on the first edge where synced differs.
- Input already high at reset release: stable starts at 0, so one strobe is issued after S+D edges. This is intended.
- Reset mid-count or mid-strobe: all state clears; the count restarts from 0 after release.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

Decomposition:
- Shared package (de_ustb_pkg) holds:
  - a clog2 helper function;
  - default constants SYNC_STAGES_DEF = 2 and DEBOUNCE_CYCLES_DEF = 16.
- One sub-module is natural: de_ustb_sync, a parameterised N-stage synchroniser with async active-high reset, reused by other pad inputs.
- Debounce and strobe logic stay in de_ustb.

Test Plan:
1. Defaults; assert rst, then release with in = 0; raise in at a posedge-aligned sample and hold → out = 0 for 18 edges, out = 1 for exactly 1 cycle after the 18th edge, then 0 permanently.
2. Defaults; in high for 10 cycles, then low → out never asserts, stable stays 0.
3. Bounce: in toggles 1,0,1,0 every 3 cycles, then holds 1 → out pulses exactly once, 18 edges after the final rising sample.
4. After acceptance, drop in to 0 for 20 cycles, then raise again → no strobe on the fall; a second single strobe 18 edges after the re-rise.
5. Assert rst while the counter is at 10 and again while out = 1 → out drops to 0 asynchronously, before the next edge; after release with in held high, the strobe comes 18 edges later.
6. SYNC_STAGES = 3, DEBOUNCE_CYCLES = 1; step in to 1 → out high for exactly the cycle after the 4th edge.
